pipe_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the pc_reg, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Turns the exception type reported by MEM into a pipeline flush plus a redirect PC. The flush can be held for a programmable number of cycles.
- Also keeps a stall watchdog and two performance counters.

---
 rtl/pipe_ctrl_if.sv | 33 +++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central pipeline controller.
// The pipeline side drives stall requests and exception info; the controller drives stall/flush/redirect.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             stallreq_if_i;
   logic             stallreq_id_i;
   logic             stallreq_ex_i;
   logic             stallreq_mem_i;
   logic [31:0]      excepttype_i;
   logic [31:0]      cp0_epc_i;
   logic [5:0]       stall_o;
   logic             flush_o;
   logic [31:0]      new_pc_o;
   logic             busy_o;
   logic             stall_timeout_o;
   logic [CNT_W-1:0] stall_cycles_o;
   logic [CNT_W-1:0] flush_count_o;

   modport master (
      output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      output excepttype_i, cp0_epc_i,
      input  stall_o, flush_o, new_pc_o, busy_o, stall_timeout_o,
      input  stall_cycles_o, flush_count_o
   );

   modport slave (
      input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      input  excepttype_i, cp0_epc_i,
      output stall_o, flush_o, new_pc_o, busy_o, stall_timeout_o,
      output stall_cycles_o, flush_count_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, turns MEM exceptions into a
// (possibly multi-cycle) flush with redirect PC, and keeps a stall watchdog plus two counters.
module pipe_ctrl #(
   parameter int          FLUSH_CYCLES = 1,
   parameter int          WDOG_LIMIT   = 1023,
   parameter int          CNT_W        = 32,
   parameter logic [31:0] INT_VECTOR   = 32'h00000020,
   parameter logic [31:0] EXC_VECTOR   = 32'h00000040
) (
   input  logic          clk,
   input  logic          rst,
   pipe_ctrl_if.slave    bus
);
   localparam int WD_W = $clog2(WDOG_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);
   localparam logic [3:0] REM_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

   typedef enum logic {
      S_IDLE,
      S_FLUSH
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [3:0]       r_remaining;
   logic [3:0]       w_remaining_next;
   logic [31:0]      r_pc_hold;
   logic [31:0]      w_pc_hold_next;
   logic [WD_W-1:0]  r_wd_cnt;
   logic [WD_W-1:0]  w_wd_next;
   logic             r_timeout;
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;

   logic [5:0]       w_stall;
   logic             w_flush;
   logic [31:0]      w_new_pc;
   logic             w_busy;
   logic             w_accept;
   logic [31:0]      w_exc_pc;
   logic [5:0]       w_stall_req;

   // Redirect target for the exception currently reported by MEM.
   always_comb begin
      w_exc_pc = EXC_VECTOR;
      case (bus.excepttype_i)
         32'h0000_0001: w_exc_pc = INT_VECTOR;
         32'h0000_000e: w_exc_pc = bus.cp0_epc_i;
         default:       w_exc_pc = EXC_VECTOR;
      endcase
   end

   // The deepest stalling stage freezes itself and every stage upstream of it.
   always_comb begin
      w_stall_req = 6'b000000;
      if (bus.stallreq_mem_i)
         w_stall_req = 6'b011111;
      else if (bus.stallreq_ex_i)
         w_stall_req = 6'b001111;
      else if (bus.stallreq_id_i)
         w_stall_req = 6'b000111;
      else if (bus.stallreq_if_i)
         w_stall_req = 6'b000011;
   end

   always_comb begin
      w_state_next     = r_state;
      w_remaining_next = r_remaining;
      w_pc_hold_next   = r_pc_hold;
      w_stall          = 6'b000000;
      w_flush          = 1'b0;
      w_new_pc         = 32'h0;
      w_busy           = 1'b0;
      w_accept         = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (bus.excepttype_i != 32'h0) begin
                  w_flush  = 1'b1;
                  w_new_pc = w_exc_pc;
                  w_accept = 1'b1;
                  if (MULTI_FLUSH) begin
                     w_state_next     = S_FLUSH;
                     w_remaining_next = REM_LOAD;
                     w_pc_hold_next   = w_exc_pc;
                  end
               end else begin
                  w_stall = w_stall_req;
               end
            end
            S_FLUSH: begin
               // Inputs are ignored here; the redirect comes from the latched PC.
               w_flush          = 1'b1;
               w_new_pc         = r_pc_hold;
               w_busy           = 1'b1;
               w_remaining_next = r_remaining - 4'd1;
               if (r_remaining == 4'd1)
                  w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_wd_next = '0;
      if (w_stall != 6'b000000)
         w_wd_next = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_remaining    <= 4'd0;
         r_pc_hold      <= 32'h0;
         r_wd_cnt       <= '0;
         r_timeout      <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_remaining <= w_remaining_next;
         r_pc_hold   <= w_pc_hold_next;
         r_wd_cnt    <= w_wd_next;
         if (w_wd_next == WD_MAX)
            r_timeout <= 1'b1;
         if (w_stall != 6'b000000)
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (w_accept)
            r_flush_count <= r_flush_count + CNT_W'(1);
      end
   end

   assign bus.stall_o         = w_stall;
   assign bus.flush_o         = w_flush;
   assign bus.new_pc_o        = w_new_pc;
   assign bus.busy_o          = w_busy;
   assign bus.stall_timeout_o = r_timeout;
   assign bus.stall_cycles_o  = r_stall_cycles;
   assign bus.flush_count_o   = r_flush_count;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (3-cycle and 1-cycle flush) share one stimulus stream
// and are checked every cycle against a behavioural model, plus directed literal scenarios.
module tb_pipe_ctrl;
   localparam int FL_A = 3;
   localparam int FL_B = 1;
   localparam int WD   = 4;

   logic        clk;
   logic        rst;
   logic        s_if, s_id, s_ex, s_mem;
   logic [31:0] exc;
   logic [31:0] epc;
   int          checks;
   int          failures;
   bit          cmp_en;

   pipe_ctrl_if #(.CNT_W(32)) bus_a ();
   pipe_ctrl_if #(.CNT_W(8))  bus_b ();

   assign bus_a.stallreq_if_i  = s_if;
   assign bus_a.stallreq_id_i  = s_id;
   assign bus_a.stallreq_ex_i  = s_ex;
   assign bus_a.stallreq_mem_i = s_mem;
   assign bus_a.excepttype_i   = exc;
   assign bus_a.cp0_epc_i      = epc;
   assign bus_b.stallreq_if_i  = s_if;
   assign bus_b.stallreq_id_i  = s_id;
   assign bus_b.stallreq_ex_i  = s_ex;
   assign bus_b.stallreq_mem_i = s_mem;
   assign bus_b.excepttype_i   = exc;
   assign bus_b.cp0_epc_i      = epc;

   pipe_ctrl #(.FLUSH_CYCLES(FL_A), .WDOG_LIMIT(WD), .CNT_W(32)) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave));
   pipe_ctrl #(.FLUSH_CYCLES(FL_B), .WDOG_LIMIT(WD), .CNT_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state per instance: flush cycles still owed, held PC, watchdog run, counters.
   int          m_rem[2];
   logic [31:0] m_pc[2];
   int          m_wd[2];
   bit          m_to[2];
   longint      m_sc[2];
   longint      m_fc[2];

   function automatic int fl_of(input int k);
      return (k == 0) ? FL_A : FL_B;
   endfunction

   function automatic logic [31:0] target(input logic [31:0] e, input logic [31:0] ep);
      if (e == 32'h1) return 32'h20;
      if (e == 32'he) return ep;
      return 32'h40;
   endfunction

   function automatic logic [5:0] e_stall(input int k);
      if (rst || m_rem[k] > 0 || exc != 0) return 6'd0;
      if (s_mem) return 6'b011111;
      if (s_ex)  return 6'b001111;
      if (s_id)  return 6'b000111;
      if (s_if)  return 6'b000011;
      return 6'd0;
   endfunction

   function automatic logic e_flush(input int k);
      if (rst) return 1'b0;
      return (m_rem[k] > 0) || (exc != 0);
   endfunction

   function automatic logic [31:0] e_pc(input int k);
      if (rst) return 32'h0;
      if (m_rem[k] > 0) return m_pc[k];
      return target(exc, epc);
   endfunction

   function automatic logic e_busy(input int k);
      return !rst && (m_rem[k] > 0);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_rem[k] <= 0;
            m_pc[k]  <= 32'h0;
            m_wd[k]  <= 0;
            m_to[k]  <= 1'b0;
            m_sc[k]  <= 0;
            m_fc[k]  <= 0;
         end else begin
            if (m_rem[k] > 0) begin
               m_rem[k] <= m_rem[k] - 1;
            end else if (exc != 0) begin
               m_fc[k] <= m_fc[k] + 1;
               if (fl_of(k) > 1) begin
                  m_rem[k] <= fl_of(k) - 1;
                  m_pc[k]  <= target(exc, epc);
               end
            end
            if (e_stall(k) != 6'd0) begin
               m_sc[k] <= m_sc[k] + 1;
               if (m_wd[k] < WD) m_wd[k] <= m_wd[k] + 1;
               if (m_wd[k] >= WD - 1) m_to[k] <= 1'b1;
            end else begin
               m_wd[k] <= 0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int k, input logic [5:0] st, input logic fl, input logic [31:0] pc,
                           input logic bz, input logic to, input logic [63:0] sc,
                           input logic [63:0] fc, input logic [63:0] mask);
      chk($sformatf("stall_%0d", k), {58'd0, st}, {58'd0, e_stall(k)});
      chk($sformatf("flush_%0d", k), {63'd0, fl}, {63'd0, e_flush(k)});
      if (rst || e_flush(k))
         chk($sformatf("new_pc_%0d", k), {32'd0, pc}, {32'd0, e_pc(k)});
      chk($sformatf("busy_%0d", k), {63'd0, bz}, {63'd0, e_busy(k)});
      chk($sformatf("timeout_%0d", k), {63'd0, to}, {63'd0, m_to[k]});
      chk($sformatf("stall_cycles_%0d", k), sc, 64'(m_sc[k]) & mask);
      chk($sformatf("flush_count_%0d", k), fc, 64'(m_fc[k]) & mask);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_inst(0, bus_a.stall_o, bus_a.flush_o, bus_a.new_pc_o, bus_a.busy_o,
                  bus_a.stall_timeout_o, {32'd0, bus_a.stall_cycles_o},
                  {32'd0, bus_a.flush_count_o}, 64'hFFFF_FFFF);
         cmp_inst(1, bus_b.stall_o, bus_b.flush_o, bus_b.new_pc_o, bus_b.busy_o,
                  bus_b.stall_timeout_o, {56'd0, bus_b.stall_cycles_o},
                  {56'd0, bus_b.flush_count_o}, 64'hFF);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; exc = 0; epc = 0;
   endtask

   task automatic do_reset;
      rst = 1;
      clear_inputs();
      @(negedge clk);
      tick();
      rst = 0;
   endtask

   initial begin
      checks = 0; failures = 0; cmp_en = 0;
      rst = 1;
      clear_inputs();
      @(negedge clk);
      chk("rst_stall", {58'd0, bus_a.stall_o}, 64'd0);
      chk("rst_flush", {63'd0, bus_a.flush_o}, 64'd0);
      chk("rst_new_pc", {32'd0, bus_a.new_pc_o}, 64'd0);
      chk("rst_busy", {63'd0, bus_a.busy_o}, 64'd0);
      tick();
      rst = 0;
      cmp_en = 1;

      // Stall priority
      s_id = 1;
      @(negedge clk); chk("prio_id", {58'd0, bus_a.stall_o}, 64'b000111);
      tick(); s_mem = 1;
      @(negedge clk); chk("prio_mem", {58'd0, bus_a.stall_o}, 64'b011111);
      tick(); s_id = 0; s_mem = 0;
      @(negedge clk); chk("prio_none", {58'd0, bus_a.stall_o}, 64'd0);
      tick();

      // Syscall while EX stalls
      do_reset();
      exc = 32'h8; s_ex = 1;
      @(negedge clk);
      chk("sys_flush", {63'd0, bus_b.flush_o}, 64'd1);
      chk("sys_pc", {32'd0, bus_b.new_pc_o}, 64'h40);
      chk("sys_stall", {58'd0, bus_b.stall_o}, 64'd0);
      tick(); exc = 0; s_ex = 0;
      @(negedge clk);
      chk("sys_count", {56'd0, bus_b.flush_count_o}, 64'd1);
      chk("sys_flush_end", {63'd0, bus_b.flush_o}, 64'd0);
      tick();

      // ERET with 3-cycle flush; interrupt during flush is ignored
      do_reset();
      exc = 32'he; epc = 32'h1234;
      @(negedge clk);
      chk("eret_c1_flush", {63'd0, bus_a.flush_o}, 64'd1);
      chk("eret_c1_pc", {32'd0, bus_a.new_pc_o}, 64'h1234);
      chk("eret_c1_busy", {63'd0, bus_a.busy_o}, 64'd0);
      tick(); exc = 32'h1; epc = 32'h5555;
      @(negedge clk);
      chk("eret_c2_flush", {63'd0, bus_a.flush_o}, 64'd1);
      chk("eret_c2_pc", {32'd0, bus_a.new_pc_o}, 64'h1234);
      chk("eret_c2_busy", {63'd0, bus_a.busy_o}, 64'd1);
      tick(); exc = 0;
      @(negedge clk);
      chk("eret_c3_flush", {63'd0, bus_a.flush_o}, 64'd1);
      chk("eret_c3_pc", {32'd0, bus_a.new_pc_o}, 64'h1234);
      chk("eret_c3_busy", {63'd0, bus_a.busy_o}, 64'd1);
      tick();
      @(negedge clk);
      chk("eret_c4_flush", {63'd0, bus_a.flush_o}, 64'd0);
      chk("eret_c4_busy", {63'd0, bus_a.busy_o}, 64'd0);
      chk("eret_count", {32'd0, bus_a.flush_count_o}, 64'd1);
      tick();

      // Watchdog at limit 4
      do_reset();
      s_ex = 1;
      repeat (3) tick();
      s_ex = 0;
      @(negedge clk); chk("wd_3_cycles", {63'd0, bus_a.stall_timeout_o}, 64'd0);
      tick(); s_ex = 1;
      repeat (4) tick();
      s_ex = 0;
      @(negedge clk);
      chk("wd_4_cycles", {63'd0, bus_a.stall_timeout_o}, 64'd1);
      chk("wd_stall_cycles", {32'd0, bus_a.stall_cycles_o}, 64'd7);
      tick();
      @(negedge clk); chk("wd_sticky", {63'd0, bus_a.stall_timeout_o}, 64'd1);
      tick();

      // Reset in the second flush cycle
      do_reset();
      exc = 32'h8;
      @(negedge clk); chk("rmf_c1_flush", {63'd0, bus_a.flush_o}, 64'd1);
      tick(); exc = 0; rst = 1;
      @(negedge clk); chk("rmf_rst_flush", {63'd0, bus_a.flush_o}, 64'd0);
      tick(); rst = 0;
      @(negedge clk);
      chk("rmf_flush", {63'd0, bus_a.flush_o}, 64'd0);
      chk("rmf_busy", {63'd0, bus_a.busy_o}, 64'd0);
      chk("rmf_fcount", {32'd0, bus_a.flush_count_o}, 64'd0);
      chk("rmf_scount", {32'd0, bus_a.stall_cycles_o}, 64'd0);
      chk("rmf_timeout", {63'd0, bus_a.stall_timeout_o}, 64'd0);
      tick();

      // Interrupt and unknown code
      do_reset();
      exc = 32'h1;
      @(negedge clk); chk("int_pc", {32'd0, bus_b.new_pc_o}, 64'h20);
      tick(); exc = 32'h7;
      @(negedge clk); chk("unk_pc", {32'd0, bus_b.new_pc_o}, 64'h40);
      tick(); exc = 0;

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 149) == 0);
         s_if  = ($urandom_range(0, 2) == 0);
         s_id  = ($urandom_range(0, 2) == 0);
         s_ex  = ($urandom_range(0, 3) == 0);
         s_mem = ($urandom_range(0, 4) == 0);
         epc   = $urandom;
         if ($urandom_range(0, 9) < 8) begin
            exc = 32'h0;
         end else begin
            case ($urandom_range(0, 6))
               0: exc = 32'h1;
               1: exc = 32'h8;
               2: exc = 32'ha;
               3: exc = 32'hc;
               4: exc = 32'hd;
               5: exc = 32'he;
               default: exc = $urandom | 32'h100;
            endcase
         end
         @(negedge clk);
         tick();
      end
      rst = 0;
      clear_inputs();
      @(negedge clk);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
